vend_coin_scheduler: RTL

Shares one vending-machine core (price 20 cents, change reported in nickels) between two customer panels, A and B. Each panel pushes coin events into a private FIFO. The scheduler grants the core to one panel per transaction and feeds that panel's coins to the core as one-hot single-cycle pulses. It then routes the core's soda/change result back to the owning panel. It sits between the panel coin acceptors and the core's nickle/dime/quarter inputs.

---
 rtl/vend_coin_scheduler.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/vend_coin_scheduler.sv
// Two-panel front end for a single 20-cent vending core: per-panel coin FIFOs,
// a round-robin transaction owner, one-hot coin pulses to the core and vend routing.

module vend_coin_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:0] in_type,
  output logic       in_ready,
  input  logic       pop,
  output logic [1:0] head,
  output logic       not_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;

  // Illegal type 00 completes the handshake but never occupies an entry.
  assign in_ready  = (count != (AW+1)'(DEPTH));
  assign push      = in_valid && in_ready && (in_type != 2'b00);
  assign head      = mem[rd_ptr];
  assign not_empty = (count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_type;
  end
endmodule

module vend_coin_scheduler #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_coin_valid,
  input  logic [1:0] a_coin_type,
  output logic       a_coin_ready,
  input  logic       b_coin_valid,
  input  logic [1:0] b_coin_type,
  output logic       b_coin_ready,
  output logic       core_nickle,
  output logic       core_dime,
  output logic       core_quarter,
  input  logic       core_soda,
  input  logic [2:0] core_change,
  output logic       vend_a,
  output logic       vend_b,
  output logic [2:0] change_out,
  output logic [1:0] owner,
  output logic       busy
);
  typedef enum logic [1:0] {S_IDLE, S_FEED, S_WAIT, S_DONE} state_t;

  state_t     state;
  logic       rr_ptr;
  logic [1:0] a_head;
  logic [1:0] b_head;
  logic       a_not_empty;
  logic       b_not_empty;
  logic       a_pop;
  logic       b_pop;
  logic       grant_valid;
  logic       grant_b;
  logic [1:0] grant_head;

  vend_coin_fifo #(.DEPTH(DEPTH)) fifo_a (
    .clk(clk), .rst(rst), .in_valid(a_coin_valid), .in_type(a_coin_type),
    .in_ready(a_coin_ready), .pop(a_pop), .head(a_head), .not_empty(a_not_empty)
  );

  vend_coin_fifo #(.DEPTH(DEPTH)) fifo_b (
    .clk(clk), .rst(rst), .in_valid(b_coin_valid), .in_type(b_coin_type),
    .in_ready(b_coin_ready), .pop(b_pop), .head(b_head), .not_empty(b_not_empty)
  );

  // grant_valid marks the edge that enters FEED; the chosen FIFO is popped on that same edge.
  always_comb begin
    grant_valid = 1'b0;
    grant_b     = 1'b0;
    case (state)
      S_IDLE: begin
        if (a_not_empty && b_not_empty) begin
          grant_valid = 1'b1;
          grant_b     = rr_ptr;
        end else if (a_not_empty) begin
          grant_valid = 1'b1;
        end else if (b_not_empty) begin
          grant_valid = 1'b1;
          grant_b     = 1'b1;
        end
      end
      S_WAIT: begin
        if (!core_soda) begin
          grant_b     = (owner == 2'b10);
          grant_valid = grant_b ? b_not_empty : a_not_empty;
        end
      end
      default: ;
    endcase
  end

  assign a_pop      = grant_valid && !grant_b;
  assign b_pop      = grant_valid && grant_b;
  assign grant_head = grant_b ? b_head : a_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      rr_ptr       <= 1'b0;
      owner        <= 2'b00;
      busy         <= 1'b0;
      core_nickle  <= 1'b0;
      core_dime    <= 1'b0;
      core_quarter <= 1'b0;
      vend_a       <= 1'b0;
      vend_b       <= 1'b0;
      change_out   <= 3'd0;
    end else begin
      core_nickle  <= 1'b0;
      core_dime    <= 1'b0;
      core_quarter <= 1'b0;
      vend_a       <= 1'b0;
      vend_b       <= 1'b0;
      change_out   <= 3'd0;
      if (grant_valid) begin
        core_nickle  <= (grant_head == 2'b01);
        core_dime    <= (grant_head == 2'b10);
        core_quarter <= (grant_head == 2'b11);
      end
      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            state <= S_FEED;
            owner <= grant_b ? 2'b10 : 2'b01;
            busy  <= 1'b1;
          end
        end
        S_FEED: state <= S_WAIT;
        S_WAIT: begin
          // Ownership is held until the core vends; the other panel simply queues.
          if (core_soda) begin
            state      <= S_DONE;
            change_out <= core_change;
            vend_a     <= (owner == 2'b01);
            vend_b     <= (owner == 2'b10);
          end else if (grant_valid) begin
            state <= S_FEED;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          owner  <= 2'b00;
          busy   <= 1'b0;
          rr_ptr <= (owner == 2'b01);
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
